// File: rtl/matrix_loader.sv
// matrix_loader
//   Double-buffered operand store feeding mmu_feeder. A host byte stream is
//   assembled into sets of 8 bytes (2x2 weights then 2x2 inputs). Two banks
//   ping-pong: the host fills one while the other is presented for compute.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   host_indata   host operand byte
//   host_valid    byte valid this cycle
//   host_ready    write bank can accept a byte
//   compute_done  one-cycle pulse: current set consumed
//   compute_en    high while the read bank holds a full set (feeder en)
//   weight_0..3   read-bank weights, row-major
//   input_0..3    read-bank inputs, row-major
//   banks_full    number of full banks (0..2)
//   overrun       sticky: byte offered while host_ready was low
module matrix_loader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] host_indata,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              compute_done,
    output logic              compute_en,
    output logic [DATA_W-1:0] weight_0,
    output logic [DATA_W-1:0] weight_1,
    output logic [DATA_W-1:0] weight_2,
    output logic [DATA_W-1:0] weight_3,
    output logic [DATA_W-1:0] input_0,
    output logic [DATA_W-1:0] input_1,
    output logic [DATA_W-1:0] input_2,
    output logic [DATA_W-1:0] input_3,
    output logic [1:0]        banks_full,
    output logic              overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [0:1][0:7];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [2:0]        wr_ptr;
    logic              accept;
    logic              fill_done;
    logic              release_set;

    assign host_ready  = !full[wr_bank];
    assign accept      = host_valid && host_ready;
    assign fill_done   = accept && (wr_ptr == 3'd7);
    assign release_set = (state == RUN) && compute_done;
    assign banks_full  = {1'b0, full[0]} + {1'b0, full[1]};

    // Write side: byte storage and write pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    mem[b][i] <= '0;
                end
            end
            wr_ptr  <= 3'd0;
            wr_bank <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_bank][wr_ptr] <= host_indata;
                wr_ptr               <= wr_ptr + 3'd1;
                if (fill_done) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (host_valid && !host_ready) begin
                overrun <= 1'b1;
            end
        end
    end

    // Full flags: a fill and a release always target different banks,
    // since a bank in RUN is full and a full bank is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (fill_done && (wr_bank == b[0])) begin
                    full[b] <= 1'b1;
                end else if (release_set && (rd_bank == b[0])) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_bank    <= 1'b0;
            compute_en <= 1'b0;
        end else begin
            state      <= state_next;
            compute_en <= (state_next == RUN);
            if (release_set) begin
                rd_bank <= !rd_bank;
            end
        end
    end

    // Read FSM next state; leaving RUN always passes through IDLE for one
    // cycle so the feeder sees en low between sets.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (full[rd_bank]) state_next = RUN;
            RUN:     if (compute_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand outputs track the read bank every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_0 <= '0;
            weight_1 <= '0;
            weight_2 <= '0;
            weight_3 <= '0;
            input_0  <= '0;
            input_1  <= '0;
            input_2  <= '0;
            input_3  <= '0;
        end else begin
            weight_0 <= mem[rd_bank][0];
            weight_1 <= mem[rd_bank][1];
            weight_2 <= mem[rd_bank][2];
            weight_3 <= mem[rd_bank][3];
            input_0  <= mem[rd_bank][4];
            input_1  <= mem[rd_bank][5];
            input_2  <= mem[rd_bank][6];
            input_3  <= mem[rd_bank][7];
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader
//   Directed bench for matrix_loader: reset, single load, ping-pong,
//   back-pressure/overrun, simultaneous fill/release, reset mid-fill.
module tb_matrix_loader;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] host_indata;
    logic              host_valid;
    logic              host_ready;
    logic              compute_done;
    logic              compute_en;
    logic [DATA_W-1:0] weight_0, weight_1, weight_2, weight_3;
    logic [DATA_W-1:0] input_0, input_1, input_2, input_3;
    logic [1:0]        banks_full;
    logic              overrun;

    int errors = 0;
    int checks = 0;

    matrix_loader #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .host_indata  (host_indata),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .compute_done (compute_done),
        .compute_en   (compute_en),
        .weight_0     (weight_0),
        .weight_1     (weight_1),
        .weight_2     (weight_2),
        .weight_3     (weight_3),
        .input_0      (input_0),
        .input_1      (input_1),
        .input_2      (input_2),
        .input_3      (input_3),
        .banks_full   (banks_full),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        host_valid  = 1'b1;
        host_indata = b;
        tick();
        host_valid  = 1'b0;
    endtask

    task automatic pulse_done();
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        host_valid   = 1'b1;
        host_indata  = 8'h55;
        compute_done = 1'b0;
        tick();
        tick();

        // Reset state with host_valid held high
        chk("rst_host_ready", host_ready, 1);
        chk("rst_compute_en", compute_en, 0);
        chk("rst_banks_full", banks_full, 0);
        chk("rst_overrun",    overrun, 0);
        chk("rst_weight_0",   weight_0, 0);
        chk("rst_input_3",    input_3, 0);
        rst        = 1'b0;
        host_valid = 1'b0;
        tick();

        // Single load 1..8
        for (int i = 1; i <= 8; i++) send_byte(i[7:0]);
        chk("single_en_not_yet", compute_en, 0);
        chk("single_banks_full", banks_full, 1);
        tick();
        chk("single_en",       compute_en, 1);
        chk("single_weight_0", weight_0, 1);
        chk("single_weight_1", weight_1, 2);
        chk("single_weight_2", weight_2, 3);
        chk("single_weight_3", weight_3, 4);
        chk("single_input_0",  input_0, 5);
        chk("single_input_1",  input_1, 6);
        chk("single_input_2",  input_2, 7);
        chk("single_input_3",  input_3, 8);

        // Ping-pong: load 9..16 while running on 1..8
        for (int i = 9; i <= 16; i++) send_byte(i[7:0]);
        chk("pp_banks_full2", banks_full, 2);
        chk("pp_hold_w0",     weight_0, 1);
        chk("pp_hold_i3",     input_3, 8);
        chk("pp_en_hold",     compute_en, 1);
        chk("pp_ready_low",   host_ready, 0);
        pulse_done();
        chk("pp_en_gap",      compute_en, 0);
        chk("pp_banks_full1", banks_full, 1);
        chk("pp_ready_back",  host_ready, 1);
        tick();
        chk("pp_en_again",    compute_en, 1);
        chk("pp_new_w0",      weight_0, 9);
        chk("pp_new_w1",      weight_1, 10);
        chk("pp_new_i3",      input_3, 16);

        // Drain so both banks are empty
        pulse_done();
        chk("drain_en",         compute_en, 0);
        chk("drain_banks_full", banks_full, 0);
        tick();
        chk("drain_en_stays_low", compute_en, 0);

        // Back-pressure: 16 bytes 0x31..0x40, no compute_done
        for (int i = 1; i <= 16; i++) send_byte(8'h30 + i[7:0]);
        chk("bp_ready_low",  host_ready, 0);
        chk("bp_banks_full", banks_full, 2);
        chk("bp_overrun_0",  overrun, 0);
        send_byte(8'hAA);
        chk("bp_overrun_1",  overrun, 1);
        chk("bp_still_full", banks_full, 2);
        chk("bp_w0_kept",    weight_0, 8'h31);
        chk("bp_i3_kept",    input_3, 8'h38);
        pulse_done();
        chk("bp_ready_back", host_ready, 1);
        chk("bp_overrun_st", overrun, 1);
        chk("bp_en_gap",     compute_en, 0);
        tick();
        chk("bp_en_bank1",   compute_en, 1);
        chk("bp_w0_bank1",   weight_0, 8'h39);
        chk("bp_i3_bank1",   input_3, 8'h40);

        // Freed bank 0 refilled; last byte coincides with release of bank 1
        for (int i = 0; i < 7; i++) send_byte(8'h50 + i[7:0]);
        chk("sim0_pre_full", banks_full, 1);
        host_valid   = 1'b1;
        host_indata  = 8'h57;
        compute_done = 1'b1;
        tick();
        host_valid   = 1'b0;
        compute_done = 1'b0;
        chk("sim0_banks_full", banks_full, 1);
        chk("sim0_en_gap",     compute_en, 0);
        tick();
        chk("sim0_en",         compute_en, 1);
        chk("sim0_w0",         weight_0, 8'h50);
        chk("sim0_i3",         input_3, 8'h57);

        // Bank 1 receives its 8th byte on the edge bank 0 is released
        for (int i = 0; i < 7; i++) send_byte(8'h60 + i[7:0]);
        host_valid   = 1'b1;
        host_indata  = 8'h67;
        compute_done = 1'b1;
        tick();
        host_valid   = 1'b0;
        compute_done = 1'b0;
        chk("sim1_banks_full", banks_full, 1);
        chk("sim1_en_gap",     compute_en, 0);
        tick();
        chk("sim1_en",         compute_en, 1);
        chk("sim1_w0",         weight_0, 8'h60);
        chk("sim1_w2",         weight_2, 8'h62);
        chk("sim1_i3",         input_3, 8'h67);
        chk("sim1_overrun",    overrun, 1);

        // Reset mid-fill while running
        for (int i = 0; i < 5; i++) send_byte(8'h70 + i[7:0]);
        rst = 1'b1;
        #1;
        chk("mid_rst_en_async", compute_en, 0);
        chk("mid_rst_full",     banks_full, 0);
        chk("mid_rst_overrun",  overrun, 0);
        chk("mid_rst_w0",       weight_0, 0);
        chk("mid_rst_ready",    host_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 21; i <= 28; i++) send_byte(i[7:0]);
        chk("mid_en_not_yet", compute_en, 0);
        tick();
        chk("mid_en",  compute_en, 1);
        chk("mid_w0",  weight_0, 21);
        chk("mid_w1",  weight_1, 22);
        chk("mid_i3",  input_3, 28);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
